inst_axi_rd_bridge: RTL and testbench

//  Converts the fetch stage's SRAM-like instruction request/response interface into AXI4 AR/R channels.

---
 rtl/inst_axi_rd_bridge_pkg.sv | 15 +
 rtl/inst_axi_rd_bridge.sv | 119 +++++++++++
 tb/tb_inst_axi_rd_bridge.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared AXI read-channel constants and AR FSM state encoding for the
// instruction-fetch AXI read bridge.
package inst_axi_rd_bridge_pkg;

    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [7:0] ARLEN_SINGLE = 8'd0;
    localparam logic [1:0] SIZE_WORD    = 2'h2;
    localparam logic [1:0] LOCK_NORMAL  = 2'b00;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        AR_WAIT = 1'b1
    } ar_state_t;

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-fetch bridge: SRAM-like req/addr_ok/data_ok to single-beat AXI4
// reads, with an outstanding-read limit and flush-time response discarding.
//
//  state   | meaning
//  IDLE    | may accept a fetch request when below the outstanding limit
//  AR_WAIT | AR beat presented, holding araddr/arsize until arready
module inst_axi_rd_bridge
    import inst_axi_rd_bridge_pkg::*;
#(
    parameter logic [3:0] AR_ID     = 4'd0,
    parameter int         MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        flush,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rd_err
);

    localparam int CW = $clog2(MAX_OUTST + 2);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);

    ar_state_t     state_q, state_d;
    logic [31:0]   araddr_q;
    logic [1:0]    arsize_q;
    logic [CW-1:0] outst_cnt, discard_cnt;
    logic          ar_hs, r_done, ar_pending;
    logic [3:0]    rid_unused;

    // In-order return for a single ID makes rid uninformative here.
    assign rid_unused = rid;

    assign arid    = AR_ID;
    assign araddr  = araddr_q;
    assign arlen   = ARLEN_SINGLE;
    assign arsize  = {1'b0, arsize_q};
    assign arburst = BURST_INCR;
    assign arlock  = LOCK_NORMAL;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (state_q == AR_WAIT);

    assign ar_hs      = arvalid & arready;
    assign ar_pending = (state_q == AR_WAIT) & ~ar_hs;
    assign rready     = (outst_cnt != '0);
    assign r_done     = rvalid & rready & rlast;

    assign inst_sram_data_ok = r_done & (discard_cnt == '0);
    assign inst_sram_rdata   = rdata;
    assign rd_err            = r_done & (rresp != 2'b00);

    always_comb begin
        state_d           = state_q;
        inst_sram_addr_ok = 1'b0;
        case (state_q)
            IDLE: begin
                inst_sram_addr_ok = inst_sram_req & ~inst_sram_wr & ~flush
                                    & (outst_cnt < MAX_C);
                if (inst_sram_addr_ok) state_d = AR_WAIT;
            end
            AR_WAIT: begin
                if (ar_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            araddr_q <= '0;
            arsize_q <= SIZE_WORD;
        end else begin
            state_q <= state_d;
            if (inst_sram_addr_ok) begin
                araddr_q <= inst_sram_addr;
                arsize_q <= inst_sram_size;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outst_cnt   <= '0;
            discard_cnt <= '0;
        end else begin
            outst_cnt <= outst_cnt + CW'(ar_hs) - CW'(r_done);
            // Everything already issued or still waiting on AR is owed to the
            // pre-flush stream, except a beat that completes right now.
            if (flush)
                discard_cnt <= outst_cnt + CW'(ar_hs) + CW'(ar_pending) - CW'(r_done);
            else if (r_done && discard_cnt != '0)
                discard_cnt <= discard_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge: single fetch, AR back-pressure,
// outstanding limit, flush discarding, error response and async reset.
module tb_inst_axi_rd_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        flush;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready, rd_err;

    int n_checks = 0;
    int n_fail   = 0;

    inst_axi_rd_bridge #(.AR_ID(4'd0), .MAX_OUTST(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata), .flush(flush),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Accept a fetch, handshake AR on the following cycle, return in the cycle after.
    task automatic issue(input logic [31:0] a, input string tag);
        cyc(); inst_sram_req = 1'b1; inst_sram_addr = a;
        smp(); chk({tag, "_addr_ok"}, 32'(inst_sram_addr_ok), 32'd1);
        cyc(); inst_sram_req = 1'b0; arready = 1'b1;
        smp(); chk({tag, "_araddr"}, araddr, a);
        cyc(); arready = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] resp);
        rvalid = 1'b1; rlast = 1'b1; rdata = d; rresp = resp;
    endtask

    initial begin
        resetn = 1'b0; inst_sram_req = 1'b0; inst_sram_wr = 1'b0;
        inst_sram_size = 2'h2; inst_sram_addr = '0; flush = 1'b0;
        arready = 1'b0; rid = 4'd0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

        // reset state
        smp();
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
        chk("rst_data_ok", 32'(inst_sram_data_ok), 32'd0);
        chk("rst_rd_err", 32'(rd_err), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        cyc(); resetn = 1'b1;

        // write requests are never accepted
        cyc(); inst_sram_req = 1'b1; inst_sram_wr = 1'b1;
        smp(); chk("wr_addr_ok", 32'(inst_sram_addr_ok), 32'd0);

        // 1: single fetch
        cyc(); inst_sram_wr = 1'b0; inst_sram_addr = 32'h1c000000;
        smp(); chk("t1_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        chk("t1_arvalid_c0", 32'(arvalid), 32'd0);
        cyc(); inst_sram_req = 1'b0;
        smp(); chk("t1_arvalid_c1", 32'(arvalid), 32'd1);
        chk("t1_araddr", araddr, 32'h1c000000);
        chk("t1_arsize", 32'(arsize), 32'd2);
        chk("t1_arlen", 32'(arlen), 32'd0);
        chk("t1_arburst", 32'(arburst), 32'd1);
        chk("t1_arid", 32'(arid), 32'd0);
        chk("t1_rready_pre", 32'(rready), 32'd0);
        cyc(); arready = 1'b1;
        smp(); chk("t1_arvalid_c2", 32'(arvalid), 32'd1);
        cyc(); arready = 1'b0; beat(32'h02800c04, 2'b00);
        smp(); chk("t1_arvalid_done", 32'(arvalid), 32'd0);
        chk("t1_outst", 32'(dut.outst_cnt), 32'd1);
        chk("t1_data_ok", 32'(inst_sram_data_ok), 32'd1);
        chk("t1_rdata", inst_sram_rdata, 32'h02800c04);
        cyc(); rvalid = 1'b0;
        smp(); chk("t1_data_ok_off", 32'(inst_sram_data_ok), 32'd0);
        chk("t1_outst_end", 32'(dut.outst_cnt), 32'd0);

        // 2: AR back-pressure
        cyc(); inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000004;
        smp(); chk("t2_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(); inst_sram_addr = 32'h1c000040;
            smp();
            chk("t2_arvalid_hold", 32'(arvalid), 32'd1);
            chk("t2_araddr_hold", araddr, 32'h1c000004);
            chk("t2_addr_ok_low", 32'(inst_sram_addr_ok), 32'd0);
            chk("t2_outst_zero", 32'(dut.outst_cnt), 32'd0);
        end
        cyc(); inst_sram_req = 1'b0; arready = 1'b1;
        smp(); chk("t2_arvalid_hs", 32'(arvalid), 32'd1);
        cyc(); arready = 1'b0; beat(32'h11110000, 2'b00);
        smp(); chk("t2_outst_one", 32'(dut.outst_cnt), 32'd1);
        chk("t2_data_ok", 32'(inst_sram_data_ok), 32'd1);
        cyc(); rvalid = 1'b0;

        // 3: outstanding limit of two
        issue(32'h1c000010, "t3a");
        issue(32'h1c000014, "t3b");
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000018;
        smp(); chk("t3_outst_two", 32'(dut.outst_cnt), 32'd2);
        chk("t3_addr_ok_full", 32'(inst_sram_addr_ok), 32'd0);
        cyc();
        smp(); chk("t3_addr_ok_full2", 32'(inst_sram_addr_ok), 32'd0);
        cyc(); beat(32'hA1A10000, 2'b00);
        smp(); chk("t3_data_ok_a", 32'(inst_sram_data_ok), 32'd1);
        chk("t3_addr_ok_beat", 32'(inst_sram_addr_ok), 32'd0);
        cyc(); rvalid = 1'b0;
        smp(); chk("t3_addr_ok_free", 32'(inst_sram_addr_ok), 32'd1);
        cyc(); inst_sram_req = 1'b0; arready = 1'b1;
        smp(); chk("t3_araddr_c", araddr, 32'h1c000018);
        cyc(); arready = 1'b0; beat(32'hB1B10000, 2'b00);
        smp(); chk("t3_data_ok_b", 32'(inst_sram_data_ok), 32'd1);
        cyc(); beat(32'hC1C10000, 2'b00);
        smp(); chk("t3_rdata_c", inst_sram_rdata, 32'hC1C10000);
        cyc(); rvalid = 1'b0;
        smp(); chk("t3_outst_end", 32'(dut.outst_cnt), 32'd0);

        // 4: flush with two reads outstanding
        issue(32'h1c000020, "t4a");
        issue(32'h1c000024, "t4b");
        flush = 1'b1; inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000100;
        smp(); chk("t4_addr_ok_flush", 32'(inst_sram_addr_ok), 32'd0);
        cyc(); flush = 1'b0;
        smp(); chk("t4_discard", 32'(dut.discard_cnt), 32'd2);
        cyc(); inst_sram_req = 1'b0; beat(32'hAAAA0000, 2'b00);
        smp(); chk("t4_drop_a", 32'(inst_sram_data_ok), 32'd0);
        cyc(); beat(32'hBBBB0000, 2'b00);
        smp(); chk("t4_drop_b", 32'(inst_sram_data_ok), 32'd0);
        cyc(); rvalid = 1'b0;
        smp(); chk("t4_discard_end", 32'(dut.discard_cnt), 32'd0);
        issue(32'h1c000100, "t4n");
        beat(32'hCCCC0000, 2'b00);
        smp(); chk("t4_data_ok_new", 32'(inst_sram_data_ok), 32'd1);
        chk("t4_rdata_new", inst_sram_rdata, 32'hCCCC0000);
        cyc(); rvalid = 1'b0;

        // 5: flush in AR_WAIT while the older read completes
        issue(32'h1c000200, "t5p");
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000204;
        smp(); chk("t5_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        cyc(); inst_sram_req = 1'b0; flush = 1'b1; beat(32'hDDDD0000, 2'b00);
        smp(); chk("t5_data_ok_old", 32'(inst_sram_data_ok), 32'd1);
        cyc(); flush = 1'b0; rvalid = 1'b0;
        smp(); chk("t5_discard", 32'(dut.discard_cnt), 32'd1);
        chk("t5_outst", 32'(dut.outst_cnt), 32'd0);
        chk("t5_arvalid_kept", 32'(arvalid), 32'd1);
        chk("t5_araddr_kept", araddr, 32'h1c000204);
        cyc(); arready = 1'b1;
        smp(); chk("t5_arvalid_hs", 32'(arvalid), 32'd1);
        cyc(); arready = 1'b0; beat(32'hEEEE0000, 2'b00);
        smp(); chk("t5_drop", 32'(inst_sram_data_ok), 32'd0);
        cyc(); rvalid = 1'b0;
        smp(); chk("t5_discard_end", 32'(dut.discard_cnt), 32'd0);
        chk("t5_outst_end", 32'(dut.outst_cnt), 32'd0);

        // flush with nothing outstanding has no effect
        cyc(); flush = 1'b1;
        cyc(); flush = 1'b0;
        smp(); chk("idle_flush_discard", 32'(dut.discard_cnt), 32'd0);

        // 6: error response, then reset in AR_WAIT
        issue(32'h1c000300, "t6e");
        beat(32'h12345678, 2'b10);
        smp(); chk("t6_rd_err", 32'(rd_err), 32'd1);
        chk("t6_data_ok", 32'(inst_sram_data_ok), 32'd1);
        cyc(); rvalid = 1'b0; rresp = 2'b00;
        smp(); chk("t6_rd_err_off", 32'(rd_err), 32'd0);
        issue(32'h1c000304, "t6s");
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000308;
        smp(); chk("t6_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
        cyc(); inst_sram_req = 1'b0;
        smp(); chk("t6_arvalid_pre", 32'(arvalid), 32'd1);
        chk("t6_outst_pre", 32'(dut.outst_cnt), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("t6_rst_arvalid", 32'(arvalid), 32'd0);
        chk("t6_rst_outst", 32'(dut.outst_cnt), 32'd0);
        chk("t6_rst_discard", 32'(dut.discard_cnt), 32'd0);
        chk("t6_rst_rready", 32'(rready), 32'd0);
        cyc(); resetn = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
